// File: rtl/reg_file_read_pkg.sv
// Shared constants and types for the register file and its scoreboard.
package reg_file_read_pkg;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Entry 0 always reads as zero and can never be reserved.
  localparam reg_addr_t ZERO_REG = '0;

endpackage : reg_file_read_pkg

// File: rtl/reg_file_read_if.sv
// Bus between writeback/decode and the register file.
//
// There is no valid/ready flow control here: every input strobe
// (regWrite, reserve, readEn) acts in the cycle it is high, and
// read results appear on the clock after readEn and hold until the next readEn.
// stall is a one-cycle flag that goes with the read that produced it.
interface reg_file_read_if;
  import reg_file_read_pkg::*;

  // writeback side
  logic      regWrite;
  reg_addr_t writeAddr;
  data_t     writeData;

  // issue side
  logic      reserve;
  reg_addr_t reserveAddr;

  // decode read side
  logic      readEn;
  reg_addr_t readAddrA;
  reg_addr_t readAddrB;
  data_t     readDataA;
  data_t     readDataB;
  logic      readReadyA;
  logic      readReadyB;
  logic      stall;

  // The pipeline drives requests and consumes read results.
  modport master (
    output regWrite, writeAddr, writeData,
    output reserve, reserveAddr,
    output readEn, readAddrA, readAddrB,
    input  readDataA, readDataB, readReadyA, readReadyB, stall
  );

  // The register file consumes requests and produces read results.
  modport slave (
    input  regWrite, writeAddr, writeData,
    input  reserve, reserveAddr,
    input  readEn, readAddrA, readAddrB,
    output readDataA, readDataB, readReadyA, readReadyB, stall
  );

endinterface : reg_file_read_if

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: reserve sets a bit, writeback clears it, and a
// same-cycle reserve beats a writeback because it is the newer instruction.
// The busy state of two addresses is looked up for the read ports.
module reg_scoreboard
  import reg_file_read_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      set_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t addr_a_i,
  input  reg_addr_t addr_b_i,
  output logic      busy_a_o,
  output logic      busy_b_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Apply the clear first, then the set, so the set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (clr_i && (clr_addr_i != ZERO_REG)) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_i && (set_addr_i != ZERO_REG)) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy vector register; reset drops all outstanding reservations.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups see the state before this cycle's updates.
  assign busy_a_o = busy_q[addr_a_i];
  assign busy_b_o = busy_q[addr_b_i];

endmodule : reg_scoreboard

// File: rtl/reg_file_read.sv
// 32-entry register file with two registered read ports, one write port,
// write-to-read bypass and a busy scoreboard that reports pending operands.
module reg_file_read
  import reg_file_read_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  reg_file_read_if.slave  bus
);

  data_t mem_q [NUM_REGS];

  data_t data_a_q, data_a_d;
  data_t data_b_q, data_b_d;
  logic  ready_a_q, ready_a_d;
  logic  ready_b_q, ready_b_d;
  logic  stall_q, stall_d;

  logic  busy_a;
  logic  busy_b;
  logic  wr_en;

  assign wr_en = bus.regWrite && (bus.writeAddr != ZERO_REG);

  reg_scoreboard u_scoreboard (
    .clk_i      (clk),
    .reset_i    (reset),
    .set_i      (bus.reserve),
    .set_addr_i (bus.reserveAddr),
    .clr_i      (bus.regWrite),
    .clr_addr_i (bus.writeAddr),
    .addr_a_i   (bus.readAddrA),
    .addr_b_i   (bus.readAddrB),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b)
  );

  // Register storage; entry 0 is never written and stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[bus.writeAddr] <= bus.writeData;
    end
  end

  // Next read-port values: zero register, then bypass, then storage.
  // A same-cycle reserve is ignored here because the reader is older.
  always_comb begin
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    ready_a_d = ready_a_q;
    ready_b_d = ready_b_q;
    stall_d   = 1'b0;
    if (bus.readEn) begin
      if (bus.readAddrA == ZERO_REG) begin
        data_a_d  = '0;
        ready_a_d = 1'b1;
      end else if (bus.regWrite && (bus.writeAddr == bus.readAddrA)) begin
        data_a_d  = bus.writeData;
        ready_a_d = 1'b1;
      end else begin
        data_a_d  = mem_q[bus.readAddrA];
        ready_a_d = ~busy_a;
      end

      if (bus.readAddrB == ZERO_REG) begin
        data_b_d  = '0;
        ready_b_d = 1'b1;
      end else if (bus.regWrite && (bus.writeAddr == bus.readAddrB)) begin
        data_b_d  = bus.writeData;
        ready_b_d = 1'b1;
      end else begin
        data_b_d  = mem_q[bus.readAddrB];
        ready_b_d = ~busy_b;
      end

      stall_d = ~(ready_a_d & ready_b_d);
    end
  end

  // Output registers; operands idle as zero and ready after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_a_q  <= '0;
      data_b_q  <= '0;
      ready_a_q <= 1'b1;
      ready_b_q <= 1'b1;
      stall_q   <= 1'b0;
    end else begin
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      ready_a_q <= ready_a_d;
      ready_b_q <= ready_b_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.readDataA  = data_a_q;
  assign bus.readDataB  = data_b_q;
  assign bus.readReadyA = ready_a_q;
  assign bus.readReadyB = ready_b_q;
  assign bus.stall      = stall_q;

endmodule : reg_file_read

// File: tb/tb_reg_file_read.sv
// Bench for reg_file_read: directed scenarios plus random traffic, all
// compared against a behavioural model of the register file.
module tb_reg_file_read;
  import reg_file_read_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  reg_file_read_if bus ();

  reg_file_read dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic [31:0] e_da, e_db;
  logic        e_ra, e_rb, e_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    e_da = '0; e_db = '0; e_ra = 1'b1; e_rb = 1'b1; e_stall = 1'b0;
  endtask

  // value and readiness a decode-stage read would see right now
  task automatic model_lookup(input int a, output logic [31:0] d, output logic r);
    if (a == 0) begin
      d = '0; r = 1'b1;
    end else if (bus.regWrite && int'(bus.writeAddr) == a) begin
      d = bus.writeData; r = 1'b1;
    end else begin
      d = m_mem[a]; r = !m_busy[a];
    end
  endtask

  // advance the model by one clock using the inputs held at this edge
  task automatic model_clock();
    if (reset) begin
      model_reset();
    end else begin
      if (bus.readEn) begin
        model_lookup(int'(bus.readAddrA), e_da, e_ra);
        model_lookup(int'(bus.readAddrB), e_db, e_rb);
        e_stall = !(e_ra && e_rb);
      end else begin
        e_stall = 1'b0;
      end
      if (bus.regWrite && bus.writeAddr != 0) begin
        m_mem[bus.writeAddr]  = bus.writeData;
        m_busy[bus.writeAddr] = 1'b0;
      end
      if (bus.reserve && bus.reserveAddr != 0) m_busy[bus.reserveAddr] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("dataA",  bus.readDataA,         e_da);
    check("dataB",  bus.readDataB,         e_db);
    check("readyA", 32'(bus.readReadyA),   32'(e_ra));
    check("readyB", 32'(bus.readReadyB),   32'(e_rb));
    check("stall",  32'(bus.stall),        32'(e_stall));
  endtask

  // driver tasks
  task automatic idle();
    reset = 1'b0;
    bus.regWrite = 1'b0; bus.writeAddr = '0; bus.writeData = '0;
    bus.reserve = 1'b0; bus.reserveAddr = '0;
    bus.readEn = 1'b0; bus.readAddrA = '0; bus.readAddrB = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic rd(input int a, input int b);
    bus.readEn = 1'b1; bus.readAddrA = reg_addr_t'(a); bus.readAddrB = reg_addr_t'(b);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.regWrite = 1'b1; bus.writeAddr = reg_addr_t'(a); bus.writeData = d;
  endtask

  task automatic rsv(input int a);
    bus.reserve = 1'b1; bus.reserveAddr = reg_addr_t'(a);
  endtask

  logic [31:0] hold_a, hold_b;

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    idle();

    do_reset();
    check("rst_readyA", 32'(bus.readReadyA), 32'd1);
    check("rst_stall",  32'(bus.stall),      32'd0);

    // read after reset
    idle(); rd(5, 0); step();
    check("t1_dataA", bus.readDataA, 32'h0);
    check("t1_dataB", bus.readDataB, 32'h0);
    check("t1_rdyA",  32'(bus.readReadyA), 32'd1);

    // plain write then read
    idle(); wr(5, 32'hDEADBEEF); step();
    idle(); rd(5, 0); step();
    check("t2_dataA", bus.readDataA, 32'hDEADBEEF);
    check("t2_rdyA",  32'(bus.readReadyA), 32'd1);

    // reserve, pending read, then bypassed write
    idle(); rsv(7); step();
    idle(); rd(7, 0); step();
    check("t3_rdyA",  32'(bus.readReadyA), 32'd0);
    check("t3_stall", 32'(bus.stall), 32'd1);
    idle(); wr(7, 32'h12); rd(7, 0); step();
    check("t3_bypA",  bus.readDataA, 32'h12);
    check("t3_brdy",  32'(bus.readReadyA), 32'd1);
    check("t3_bstl",  32'(bus.stall), 32'd0);

    // reserve beats write on the same register
    idle(); rsv(9); wr(9, 32'h55); step();
    idle(); rd(9, 9); step();
    check("t4_dataA", bus.readDataA, 32'h55);
    check("t4_rdyA",  32'(bus.readReadyA), 32'd0);

    // register 0 ignores write and reserve
    idle(); wr(0, 32'hFFFFFFFF); rsv(0); step();
    idle(); rd(0, 0); step();
    check("t5_dataA", bus.readDataA, 32'h0);
    check("t5_dataB", bus.readDataB, 32'h0);
    check("t5_rdyA",  32'(bus.readReadyA), 32'd1);
    check("t5_rdyB",  32'(bus.readReadyB), 32'd1);

    // reset drops reservation and data
    idle(); rsv(3); step();
    do_reset();
    idle(); rd(3, 5); step();
    check("t6_dataA", bus.readDataA, 32'h0);
    check("t6_rdyA",  32'(bus.readReadyA), 32'd1);
    check("t6_dataB", bus.readDataB, 32'h0);
    hold_a = bus.readDataA; hold_b = bus.readDataB;
    idle();
    for (int i = 0; i < 3; i++) step();
    check("t6_holdA", bus.readDataA, 32'h0);
    check("t6_holdB", bus.readDataB, 32'h0);
    check("t6_hrdy",  32'(bus.readReadyA), 32'd1);

    // random traffic, mostly on a few registers so collisions are common
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      bus.regWrite    = ($urandom_range(0, 99) < 40);
      bus.writeAddr   = reg_addr_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      bus.writeData   = $urandom;
      bus.reserve     = ($urandom_range(0, 99) < 35);
      bus.reserveAddr = reg_addr_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      bus.readEn      = ($urandom_range(0, 99) < 70);
      bus.readAddrA   = reg_addr_t'($urandom_range(0, 7));
      bus.readAddrB   = reg_addr_t'(($urandom_range(0, 4) == 0) ? bus.readAddrA : reg_addr_t'($urandom_range(0, 31)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_read

// File: doc/reg_file_read.md
Name: reg_file_read

Overview:
- 32-entry register file with two registered read ports, one write port and a per-register busy scoreboard.
- Write side: the writeback stage deposits results.
- Read side: the decode stage fetches operands and learns whether each operand is valid or still pending from an in-flight instruction.
- Read data is presented one clock after the read request, with write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of registers; entry 0 is hardwired zero.
- ADDR_WIDTH, 5, register address width, equal to log2(NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- regWrite  input  1  writeback strobe.
- writeAddr  input  ADDR_WIDTH  writeback destination.
- writeData  input  DATA_WIDTH  writeback value.
- reserve  input  1  an issuing instruction claims a destination.
- reserveAddr  input  ADDR_WIDTH  destination being claimed.
- readEn  input  1  sample both read ports this cycle.
- readAddrA  input  ADDR_WIDTH  operand A address.
- readAddrB  input  ADDR_WIDTH  operand B address.
- readDataA  output  DATA_WIDTH  operand A value, registered.
- readDataB  output  DATA_WIDTH  operand B value, registered.
- readReadyA  output  1  operand A not pending, registered.
- readReadyB  output  1  operand B not pending, registered.
- stall  output  1  registered; high when a sampled operand was pending.

Behaviour:
- Reset (reset=1 at a rising edge):
  - All entries become 0 and all busy bits 0.
  - readDataA/B=0, readReadyA/B=1, stall=0.
  - Reset dominates all concurrent regWrite, reserve and readEn.
  - Reset mid-operation discards pending reservations; no partial state survives.
- Write (regWrite=1, writeAddr!=0):
  - mem[writeAddr] <= writeData.
  - busy[writeAddr] <= 0.
  - A write to address 0 is ignored.
- Reserve (reserve=1, reserveAddr!=0):
  - busy[reserveAddr] <= 1.
  - A reserve of address 0 is ignored; entry 0 is never busy.
- Reserve and write to the same address in the same cycle: data is written and busy ends at 1, because the newer reservation wins.
- Read (readEn=1), latency 1 cycle; per port X in {A, B}:
  - addr==0: readDataX <= 0, readReadyX <= 1.
  - regWrite && writeAddr==addr (bypass): readDataX <= writeData, readReadyX <= 1.
  - Otherwise: readDataX <= mem[addr], readReadyX <= ~busy[addr].
  - stall <= ~(nextReadyA & nextReadyB).
- A same-cycle reserve does not affect readiness of the concurrent read; the reading instruction precedes the reserving one.
- readEn=0: readDataA/B and readReadyA/B hold their previous values; stall <= 0.
- Both ports may name the same address; both return identical results.
- Widths: addresses compare on the full ADDR_WIDTH; no truncation or sign handling on data.

Decomposition:
- Shared package holds:
  - constants NUM_REGS, ADDR_WIDTH, DATA_WIDTH;
  - ZERO_REG = 0;
  - a typedef for the register address and one for the data word.
- One sub-module: reg_scoreboard, which owns the NUM_REGS busy vector and implements the set/clear/priority rules and ready lookup for two addresses.
- Storage and read muxing stay in reg_file_read.

Test Plan:
- Reset, then readEn with A=5, B=0 -> next cycle readDataA=0, readDataB=0, both ready=1, stall=0.
- Write r5=0xDEADBEEF; next cycle read A=5 -> readDataA=0xDEADBEEF, readReadyA=1.
- Reserve r7; next cycle read A=7 -> readReadyA=0, stall=1. Then write r7=0x12 while reading A=7 in the same cycle -> readDataA=0x12, readReadyA=1, stall=0.
- Same cycle: reserve r9 and write r9=0x55. Next cycle read r9 -> readDataA=0x55, readReadyA=0.
- Write r0=0xFFFFFFFF and reserve r0, then read A=0, B=0 -> both data 0, both ready=1.
- Reserve r3, then assert reset. Next cycle read r3 -> readDataA=0, readReadyA=1; after readEn=0 for 3 cycles, outputs hold unchanged.
